apb_gpio_bank: RTL

- Parametrised GPIO peripheral that sits on the Cortex-M3 EMPU APB master port (psel1 slot). It supersedes the fixed 16-bit GPIO and pattern-compare LED logic.
- Adds per-channel input synchronisation and debounce, edge-triggered interrupts to user_int_0, and a software-programmable masked pattern-match output driving the board LED.

---
 rtl/apb_gpio_bank.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/apb_gpio_bank.sv
// APB GPIO bank: per-channel synchroniser and debounce, edge interrupts with W1C
// status, and a masked pattern compare driving the board LED.
module apb_gpio_bank #(
  parameter int N_CH   = 16,
  parameter int DB_W   = 16,
  parameter int DB_CYC = 60000
) (
  input  logic            sys_clk,
  input  logic            reset_n,
  input  logic            psel,
  input  logic            penable,
  input  logic [7:0]      paddr,
  input  logic            pwrite,
  input  logic [31:0]     pwdata,
  input  logic [3:0]      pstrb,
  output logic [31:0]     prdata,
  output logic            pready,
  output logic            pslverr,
  input  logic [N_CH-1:0] gpio_in,
  output logic [N_CH-1:0] gpio_out,
  output logic [N_CH-1:0] gpio_oen,
  output logic            irq,
  output logic            match_led
);

  typedef enum logic [2:0] {
    REG_OUT        = 3'd0,
    REG_OEN        = 3'd1,
    REG_IN         = 3'd2,
    REG_IRQ_EN     = 3'd3,
    REG_IRQ_POL    = 3'd4,
    REG_IRQ_STAT   = 3'd5,
    REG_MATCH_VAL  = 3'd6,
    REG_MATCH_MASK = 3'd7
  } reg_sel_e;

  // Bits at or above N_CH are masked out of every write so they always read 0.
  localparam logic [63:0]     CH_MASK_W = (64'd1 << N_CH) - 64'd1;
  localparam logic [31:0]     CH_MASK   = CH_MASK_W[31:0];
  localparam logic [DB_W-1:0] CNT_LAST  = DB_W'(DB_CYC - 1);

  logic [31:0]     out_reg;
  logic [31:0]     oen_reg;
  logic [31:0]     irq_en;
  logic [31:0]     irq_pol;
  logic [31:0]     irq_stat;
  logic [31:0]     match_val;
  logic [31:0]     match_mask;

  logic [N_CH-1:0] sync_s1;
  logic [N_CH-1:0] sync_s2;
  logic [N_CH-1:0] stable;
  logic [N_CH-1:0] stable_prev;
  logic [DB_W-1:0] db_cnt [N_CH];

  logic            addr_ok;
  reg_sel_e        reg_sel;
  logic            wr_en;
  logic [31:0]     byte_mask;
  logic [31:0]     wr_data;
  logic [31:0]     w1c;
  logic [31:0]     irq_set;
  logic [31:0]     in_word;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;

  assign addr_ok   = (paddr[1:0] == 2'b00) && (paddr[7:5] == 3'b000);
  assign reg_sel   = reg_sel_e'(paddr[4:2]);
  assign wr_en     = psel && penable && pwrite && addr_ok;
  assign byte_mask = {{8{pstrb[3]}}, {8{pstrb[2]}}, {8{pstrb[1]}}, {8{pstrb[0]}}} & CH_MASK;
  assign wr_data   = pwdata & byte_mask;

  assign pready    = 1'b1;
  assign pslverr   = psel && penable && !addr_ok;

  assign gpio_out  = out_reg[N_CH-1:0];
  assign gpio_oen  = oen_reg[N_CH-1:0];
  assign in_word   = 32'(stable);

  // Edges are taken on the debounced value, so the status bit lands one edge after IN moves.
  assign rise    = stable & ~stable_prev;
  assign fall    = ~stable & stable_prev;
  assign irq_set = 32'(irq_en[N_CH-1:0] &
                       ((~irq_pol[N_CH-1:0] & rise) | (irq_pol[N_CH-1:0] & fall)));
  assign w1c     = (wr_en && (reg_sel == REG_IRQ_STAT)) ? wr_data : 32'd0;

  assign irq = |(irq_stat & irq_en);

  function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                              input logic [31:0] mask,
                                              input logic [31:0] data);
    return (cur & ~mask) | data;
  endfunction

  always_comb begin
    prdata = 32'd0;
    if (psel && !pwrite && addr_ok) begin
      case (reg_sel)
        REG_OUT:        prdata = out_reg;
        REG_OEN:        prdata = oen_reg;
        REG_IN:         prdata = in_word;
        REG_IRQ_EN:     prdata = irq_en;
        REG_IRQ_POL:    prdata = irq_pol;
        REG_IRQ_STAT:   prdata = irq_stat;
        REG_MATCH_VAL:  prdata = match_val;
        REG_MATCH_MASK: prdata = match_mask;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      out_reg    <= '0;
      oen_reg    <= '0;
      irq_en     <= '0;
      irq_pol    <= '0;
      irq_stat   <= '0;
      match_val  <= '0;
      match_mask <= '0;
      match_led  <= 1'b0;
    end else begin
      if (wr_en) begin
        case (reg_sel)
          REG_OUT:        out_reg    <= merge_bytes(out_reg, byte_mask, wr_data);
          REG_OEN:        oen_reg    <= merge_bytes(oen_reg, byte_mask, wr_data);
          REG_IN:         ;
          REG_IRQ_EN:     irq_en     <= merge_bytes(irq_en, byte_mask, wr_data);
          REG_IRQ_POL:    irq_pol    <= merge_bytes(irq_pol, byte_mask, wr_data);
          REG_IRQ_STAT:   ;
          REG_MATCH_VAL:  match_val  <= merge_bytes(match_val, byte_mask, wr_data);
          REG_MATCH_MASK: match_mask <= merge_bytes(match_mask, byte_mask, wr_data);
        endcase
      end
      // A new event outranks a W1C landing on the same edge.
      irq_stat  <= irq_set | (irq_stat & ~w1c);
      match_led <= (match_mask != 32'd0) && (((out_reg ^ match_val) & match_mask) == 32'd0);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!reset_n) begin
      sync_s1     <= '0;
      sync_s2     <= '0;
      stable      <= '0;
      stable_prev <= '0;
      for (int i = 0; i < N_CH; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync_s1     <= gpio_in;
      sync_s2     <= sync_s1;
      stable_prev <= stable;
      // Any return to the stable level restarts the count, so short glitches never land.
      for (int i = 0; i < N_CH; i++) begin
        if (sync_s2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          stable[i] <= sync_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

endmodule
